// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - MEM-stage data memory with byte lanes, wait states and handshake.
// Optional DMEM_RANGE_CHECK_EN: out-of-range addresses fault instead of wrapping.
module data_memory_ctrl #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LP_CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_mem [DEPTH];

  logic          w_accept;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic          w_misalign;
  logic          w_addr_hi;
  logic          w_oor;
  logic          w_err;
  logic [31:0]   w_word;
  logic [31:0]   w_shift;
  logic [31:0]   w_ext;
  logic [3:0]    w_be;
  logic [31:0]   w_wlanes;
  logic          w_do_write;

  assign o_req_ready = (r_state != S_WAIT) & ~i_reset;
  assign w_accept    = i_req_valid & o_req_ready;

  assign w_idx  = r_addr[AW+1:2];
  assign w_lane = r_addr[1:0];

  assign w_misalign = (r_size == 2'b11) ||
                      (r_size == 2'b01 && r_addr[0]) ||
                      (r_size == 2'b10 && r_addr[1:0] != 2'b00);
  assign w_addr_hi  = |(r_addr >> (AW + 2));

`ifdef DMEM_RANGE_CHECK_EN
  assign w_oor = w_addr_hi;
`else
  assign w_oor = 1'b0;
  logic w_unused_addr_hi;
  assign w_unused_addr_hi = w_addr_hi;
`endif

  assign w_err = w_misalign | w_oor;

  // Array is read combinationally in DONE so a back-to-back load sees the store committed one edge earlier
  assign w_word  = r_mem[w_idx];
  assign w_shift = w_word >> {w_lane, 3'b000};

  always_comb begin
    w_ext = w_word;
    case (r_size)
      2'b00:   w_ext = r_uns ? {24'd0, w_shift[7:0]}  : {{24{w_shift[7]}}, w_shift[7:0]};
      2'b01:   w_ext = r_uns ? {16'd0, w_shift[15:0]} : {{16{w_shift[15]}}, w_shift[15:0]};
      default: w_ext = w_word;
    endcase
  end

  always_comb begin
    w_be     = 4'b1111;
    w_wlanes = r_wdata;
    case (r_size)
      2'b00: begin
        w_be     = 4'b0001 << w_lane;
        w_wlanes = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be     = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be     = 4'b1111;
        w_wlanes = r_wdata;
      end
    endcase
  end

  assign o_rsp_valid = (r_state == S_DONE) & ~i_reset;
  assign o_rsp_err   = o_rsp_valid & w_err;
  assign o_rsp_rdata = (o_rsp_valid && !r_we && !w_err) ? w_ext : 32'd0;

  assign w_do_write = (r_state == S_DONE) & r_we & ~w_err & ~i_reset;

  always_ff @(posedge i_clk) begin
    if (w_do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
    end else if (w_accept) begin
      r_we    <= i_req_we;
      r_size  <= i_req_size;
      r_uns   <= i_req_unsigned;
      r_addr  <= i_req_addr;
      r_wdata <= i_req_wdata;
      if (WAIT_STATES > 0) begin
        r_state <= S_WAIT;
        r_cnt   <= LP_CNT_INIT;
      end else begin
        r_state <= S_DONE;
      end
    end else begin
      case (r_state)
        S_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_DONE;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= r_state;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - directed bench for data_memory_ctrl with zero and three wait states.
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        rst0, rst3, v0, v3, we, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        rdy0, rdy3, rv0, rv3, err0, err3;
  logic [31:0] rd0, rd3;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  data_memory_ctrl #(.DEPTH(256), .WAIT_STATES(0), .ADDR_W(32)) u_dut0 (
    .i_clk(clk), .i_reset(rst0), .i_req_valid(v0), .o_req_ready(rdy0),
    .i_req_we(we), .i_req_size(size), .i_req_unsigned(uns), .i_req_addr(addr),
    .i_req_wdata(wdata), .o_rsp_valid(rv0), .o_rsp_rdata(rd0), .o_rsp_err(err0)
  );

  data_memory_ctrl #(.DEPTH(256), .WAIT_STATES(3), .ADDR_W(32)) u_dut3 (
    .i_clk(clk), .i_reset(rst3), .i_req_valid(v3), .o_req_ready(rdy3),
    .i_req_we(we), .i_req_size(size), .i_req_unsigned(uns), .i_req_addr(addr),
    .i_req_wdata(wdata), .o_rsp_valid(rv3), .o_rsp_rdata(rd3), .o_rsp_err(err3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic op(input bit sel, input logic w, input logic [1:0] sz, input logic u,
                    input logic [31:0] a, input logic [31:0] d,
                    output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    we = w; size = sz; uns = u; addr = a; wdata = d;
    if (sel) v3 = 1'b1; else v0 = 1'b1;
    n = 0;
    while (!(sel ? rdy3 : rdy0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0; v3 = 1'b0;
    lat = 1;
    while (!(sel ? rv3 : rv0) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = sel ? rd3 : rd0;
    er = sel ? err3 : err0;
  endtask

  task automatic tx(input string tag, input bit sel, input logic w, input logic [1:0] sz,
                    input logic u, input logic [31:0] a, input logic [31:0] d,
                    input logic [31:0] erd, input logic eer, input int elat);
    logic [31:0] rd;
    logic        er;
    int          lat;
    op(sel, w, sz, u, a, d, rd, er, lat);
    chk({tag, "_rdata"}, rd, erd);
    chk({tag, "_err"}, {31'd0, er}, {31'd0, eer});
    chk({tag, "_lat"}, lat, elat);
  endtask

  logic [8:0]  rdy_seq, rv_seq;
  logic [31:0] d1, d2;
  logic        seen;

  initial begin
    rst0 = 1'b1; rst3 = 1'b1; v0 = 1'b0; v3 = 1'b0;
    we = 1'b0; uns = 1'b0; size = 2'b00; addr = 32'd0; wdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready0", {31'd0, rdy0}, 32'd0);
    chk("rst_valid0", {31'd0, rv0}, 32'd0);
    chk("rst_rdata0", rd0, 32'd0);
    chk("rst_err0", {31'd0, err0}, 32'd0);
    chk("rst_ready3", {31'd0, rdy3}, 32'd0);
    rst0 = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    chk("idle_ready0", {31'd0, rdy0}, 32'd1);

    tx("sw10",   0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 1);
    tx("lw10",   0, 0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 1);
    tx("sb13",   0, 1, 2'b00, 0, 32'h13, 32'h12345680, 32'h0,        0, 1);
    tx("lb13",   0, 0, 2'b00, 0, 32'h13, 32'h0,        32'hFFFFFF80, 0, 1);
    tx("lbu13",  0, 0, 2'b00, 1, 32'h13, 32'h0,        32'h00000080, 0, 1);
    tx("lw10b",  0, 0, 2'b10, 0, 32'h10, 32'h0,        32'h80ADBEEF, 0, 1);
    tx("lh11",   0, 0, 2'b01, 0, 32'h11, 32'h0,        32'h0,        1, 1);
    tx("lw12",   0, 0, 2'b10, 0, 32'h12, 32'h0,        32'h0,        1, 1);
    tx("sh11",   0, 1, 2'b01, 0, 32'h11, 32'h0000FFFF, 32'h0,        1, 1);
    tx("sz3",    0, 1, 2'b11, 0, 32'h10, 32'hFFFFFFFF, 32'h0,        1, 1);
    tx("lw10c",  0, 0, 2'b10, 0, 32'h10, 32'h0,        32'h80ADBEEF, 0, 1);
    tx("lh12",   0, 0, 2'b01, 0, 32'h12, 32'h0,        32'hFFFF80AD, 0, 1);
    tx("lhu12",  0, 0, 2'b01, 1, 32'h12, 32'h0,        32'h000080AD, 0, 1);
    tx("lh10",   0, 0, 2'b01, 0, 32'h10, 32'h0,        32'hFFFFBEEF, 0, 1);
    tx("lbu11",  0, 0, 2'b00, 1, 32'h11, 32'h0,        32'h000000BE, 0, 1);
    tx("sh12",   0, 1, 2'b01, 0, 32'h12, 32'hAAAA1234, 32'h0,        0, 1);
    tx("lwu10",  0, 0, 2'b10, 1, 32'h10, 32'h0,        32'h1234BEEF, 0, 1);
    tx("sw0",    0, 1, 2'b10, 0, 32'h0,  32'h01020304, 32'h0,        0, 1);
`ifdef DMEM_RANGE_CHECK_EN
    tx("lw400",  0, 0, 2'b10, 0, 32'h400, 32'h0,       32'h0,        1, 1);
`else
    tx("lw400",  0, 0, 2'b10, 0, 32'h400, 32'h0,       32'h01020304, 0, 1);
`endif

    tx("sw3a",   1, 1, 2'b10, 0, 32'h20, 32'hCAFEF00D, 32'h0,        0, 4);
    tx("sw3b",   1, 1, 2'b10, 0, 32'h24, 32'h55AA55AA, 32'h0,        0, 4);
    tx("lh3err", 1, 0, 2'b01, 0, 32'h21, 32'h0,        32'h0,        1, 4);

    // two loads with req_valid held high: second accept lands in DONE of the first
    @(negedge clk);
    we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h20; v3 = 1'b1;
    d1 = 32'h0; d2 = 32'h0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1) addr = 32'h24;
      rdy_seq[i] = rdy3;
      rv_seq[i]  = rv3;
      if (i == 4) d1 = rd3;
      if (i == 8) d2 = rd3;
    end
    v3 = 1'b0;
    chk("pipe_ready", {23'd0, rdy_seq}, 32'h111);
    chk("pipe_valid", {23'd0, rv_seq}, 32'h110);
    chk("pipe_d1", d1, 32'hCAFEF00D);
    chk("pipe_d2", d2, 32'h55AA55AA);

    @(negedge clk);
    we = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h20; wdata = 32'h12345678; v3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v3 = 1'b0;
    rst3 = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | rv3;
    end
    chk("rst_mid_ready", {31'd0, rdy3}, 32'd0);
    rst3 = 1'b0;
    chk("rst_mid_norsp", {31'd0, seen}, 32'd0);
    tx("lw_after_rst", 1, 0, 2'b10, 0, 32'h20, 32'h0, 32'hCAFEF00D, 0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
